coef_ram_loader: RTL and testbench
==================================

Name: coef_ram_loader

Overview:
- Writer-side counterpart to the FIR coefficient ROM address counter.
- Accepts a stream of filter coefficients over a valid/ready handshake and generates write-enable, address and data for the coefficient RAM.
- Writes addresses 0..NTAPS-1 in sequence and reports completion with a signed checksum.
- Sits between the host/config interface and the coefficient RAM port A. The MAC-side read counter uses port B.

Parameters:
NTAPS, 32, number of coefficients per load (power of two, 2..256)
AW, 5, address width, equal to log2(NTAPS)
CW, 16, coefficient width (two's complement)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a load; honoured only in IDLE
abort  input  1  cancels an in-progress load
s_valid  input  1  coefficient valid
s_data  input  CW  coefficient value
s_ready  output  1  loader can accept a coefficient
we  output  1  RAM write enable
waddr  output  AW  RAM write address
wdata  output  CW  RAM write data
busy  output  1  high in LOAD and DONE states
done  output  1  one-cycle pulse when all NTAPS writes have completed
aborted  output  1  one-cycle pulse when a load is cancelled
checksum  output  CW+AW  signed sum of the coefficients accepted in the last completed load

Behaviour:
- Reset (async, rst_n=0) drives state=IDLE and we=0, waddr=0, wdata=0, done=0, aborted=0, checksum=0, internal count=0 and accumulator=0.
- Reset asserted mid-load discards the load. No done or aborted pulse is issued.
- States are IDLE, LOAD and DONE.
- s_ready = (state==LOAD) and is combinational from state only. busy = (state!=IDLE).
- IDLE:
  - start=1 moves to LOAD next cycle and clears count and accumulator.
  - abort in IDLE is ignored.
  - start while busy is ignored; there is no restart.
- LOAD:
  - An accept is s_valid & s_ready & !abort.
  - Write timing: on an accept in cycle t, cycle t+1 has we=1, waddr=count(t), wdata=s_data(t). This is one-cycle registered latency.
  - we=0 in every cycle without an accept. waddr and wdata hold their last values.
  - On an accept, count increments and accumulator += sign-extended s_data. Accumulator width is CW+AW, which cannot overflow for NTAPS coefficients.
  - When the accept has count==NTAPS-1: next state is DONE and count wraps to 0. No further accepts occur because s_ready drops at t+1.
  - Streaming: back-to-back accepts (s_valid held high) give one write per cycle with no bubbles. A full load takes NTAPS cycles of s_valid.
  - abort=1: next state is IDLE, aborted=1 for one cycle at t+1, and we=0 at t+1 even if s_valid=1 (abort wins over an accept in the same cycle).
  - On abort, checksum retains its previous value. RAM contents written so far are left as-is and are undefined for the filter.
- DONE:
  - Lasts exactly one cycle, which is the cycle after the final write is presented.
  - Registered outputs: the cycle after DONE has done=1 and checksum=final accumulator, and the state returns to IDLE.
  - Timeline for the last accept at t: t+1 gives we=1 and waddr=NTAPS-1 (state DONE); t+2 gives done=1 and checksum updated (state IDLE).
  - abort during DONE is ignored. start arriving in the same cycle that done=1 is accepted (state is already IDLE).
- checksum changes only on done.

Decomposition:
- Shared FIR package holds:
  - constants NTAPS_DEF=32, COEF_W_DEF=16 and ADDR_W_DEF=5, which are also used by the ROM address counter and the MAC;
  - the loader state enum (IDLE, LOAD, DONE).
- Single module; no sub-module is needed. The address counter is an inline AW-bit register.
- The RAM itself is external (vendor block RAM). This block only drives its write port.

Test Plan:
1. Reset then start, then 32 back-to-back coefficients 1..32 with s_valid held high → we high for 32 consecutive cycles with waddr 0..31 and wdata 1..32; done pulses 2 cycles after the last accept; checksum=528; busy drops with done.
2. Same load with s_valid toggled 1,0,1,0 → we only in the cycle after each accept; addresses remain contiguous 0..31; one done; checksum=528.
3. Signed data: 32 coefficients of -32768 → checksum=-1048576 (21-bit 0x100000); no overflow.
4. Abort after 10 accepts, asserted with s_valid=1 → no write for the abort-cycle data; aborted=1 one cycle later; state IDLE; checksum still holds its previous value (528 from test 1); done never pulses.
5. start pulsed during LOAD and abort pulsed in IDLE → both ignored: load completes normally and no aborted pulse occurs.
6. rst_n low after 5 accepts, then released and a full load of all 7s → all outputs zero during reset with no done or aborted; the following load writes waddr 0..31 and gives checksum=224.

Source files
------------

// File: rtl/coef_ram_loader_pkg.sv
// Shared FIR package: default sizing constants and the loader state type.
// NTAPS_DEF/COEF_W_DEF/ADDR_W_DEF are also used by the ROM address counter
// and the MAC, so any change here resizes the whole filter consistently.
package coef_ram_loader_pkg;

   localparam int NTAPS_DEF  = 32;
   localparam int COEF_W_DEF = 16;
   localparam int ADDR_W_DEF = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } loader_state_t;

endpackage

// File: rtl/coef_ram_loader.sv
// coef_ram_loader: writes a stream of NTAPS filter coefficients into the
// coefficient RAM write port (addresses 0..NTAPS-1 in order) and reports a
// signed checksum of the load on completion.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle load request, honoured only in IDLE
//   abort             cancels a load in progress (ignored outside LOAD)
//   s_valid/s_data    coefficient stream input
//   s_ready           high while loading; depends on state only
//   we/waddr/wdata    registered RAM write port, one cycle after each accept
//   busy              high in LOAD and DONE
//   done              one-cycle pulse after the last write of a load
//   aborted           one-cycle pulse after a cancelled load
//   checksum          signed sum of the last completed load
module coef_ram_loader
   import coef_ram_loader_pkg::*;
#(
   parameter int NTAPS = NTAPS_DEF,
   parameter int AW    = ADDR_W_DEF,
   parameter int CW    = COEF_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             s_valid,
   input  logic [CW-1:0]    s_data,
   output logic             s_ready,
   output logic             we,
   output logic [AW-1:0]    waddr,
   output logic [CW-1:0]    wdata,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [CW+AW-1:0] checksum
);

   loader_state_t     state, state_nxt;
   logic [AW-1:0]     count;
   logic [CW+AW-1:0]  acc;
   logic              accept;
   logic              last;

   // abort takes priority over a coincident valid beat
   assign accept = s_valid & (state == ST_LOAD) & ~abort;
   assign last   = (count == AW'(NTAPS - 1));

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (start) state_nxt = ST_LOAD;
         ST_LOAD: begin
            if (abort)              state_nxt = ST_IDLE;
            else if (accept && last) state_nxt = ST_DONE;
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // state-decoded outputs
   always_comb begin
      s_ready = (state == ST_LOAD);
      busy    = (state != ST_IDLE);
   end

   // write port, counter, accumulator and completion pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we       <= 1'b0;
         waddr    <= '0;
         wdata    <= '0;
         done     <= 1'b0;
         aborted  <= 1'b0;
         checksum <= '0;
         count    <= '0;
         acc      <= '0;
      end else begin
         we      <= accept;
         done    <= (state == ST_DONE);
         aborted <= (state == ST_LOAD) & abort;
         if (state == ST_IDLE && start) begin
            count <= '0;
            acc   <= '0;
         end else if (accept) begin
            waddr <= count;
            wdata <= s_data;
            // count wraps to 0 naturally after the final tap (NTAPS = 2**AW)
            count <= count + 1'b1;
            acc   <= acc + {{AW{s_data[CW-1]}}, s_data};
         end
         if (state == ST_DONE) checksum <= acc;
      end
   end

endmodule

// File: tb/tb_coef_ram_loader.sv
// Randomized self-checking bench for coef_ram_loader. A transaction-level
// model tracks how many coefficients of the current load have been taken and
// their running sum, and predicts the RAM write, pulses and checksum.
module tb_coef_ram_loader;
   import coef_ram_loader_pkg::*;

   localparam int NTAPS = NTAPS_DEF;
   localparam int AW    = ADDR_W_DEF;
   localparam int CW    = COEF_W_DEF;
   localparam int SW    = CW + AW;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start, abort, s_valid;
   logic [CW-1:0]    s_data;
   logic             s_ready, we, busy, done, aborted;
   logic [AW-1:0]    waddr;
   logic [CW-1:0]    wdata;
   logic [SW-1:0]    checksum;

   coef_ram_loader #(.NTAPS(NTAPS), .AW(AW), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .we(we), .waddr(waddr), .wdata(wdata), .busy(busy),
      .done(done), .aborted(aborted), .checksum(checksum)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // model: phase 0=idle 1=loading 2=final-write cycle
   int            phase = 0;
   int            taken = 0;
   int            sum   = 0;
   int            m_chk = 0;
   bit            e_we = 0, e_done = 0, e_ab = 0;
   int            e_waddr = 0;
   logic [CW-1:0] e_wdata = '0;
   int            coefs[NTAPS];

   function automatic logic [31:0] sw_mask(input int v);
      return 32'(v) & ((32'd1 << SW) - 32'd1);
   endfunction

   // One clock: apply inputs at edge+1, predict, then check at next edge+1.
   task automatic cycle(input bit st, input bit ab, input bit v, input int d, output bit acc);
      logic [CW-1:0] dd;
      dd = CW'(d);
      start = st; abort = ab; s_valid = v; s_data = dd;
      chk("s_ready", 32'(s_ready), 32'(phase == 1));
      chk("busy", 32'(busy), 32'(phase != 0));
      acc    = (phase == 1) && v && !ab;
      e_we   = acc;
      e_ab   = (phase == 1) && ab;
      e_done = (phase == 2);
      if (acc) begin
         e_waddr = taken;
         e_wdata = dd;
         sum    += d;
         taken++;
      end
      if (phase == 2) m_chk = sum;
      case (phase)
         0: if (st) begin phase = 1; taken = 0; sum = 0; end
         1: if (ab) phase = 0; else if (taken == NTAPS) phase = 2;
         default: phase = 0;
      endcase
      @(posedge clk); #1;
      chk("we", 32'(we), 32'(e_we));
      chk("waddr", 32'(waddr), 32'(e_waddr));
      chk("wdata", 32'(wdata), 32'(e_wdata));
      chk("done", 32'(done), 32'(e_done));
      chk("aborted", 32'(aborted), 32'(e_ab));
      chk("checksum", 32'(checksum), sw_mask(m_chk));
   endtask

   task automatic do_reset(input int ncyc);
      rst_n = 1'b0; start = 1'b1; s_valid = 1'b1; abort = 1'b0;
      #2;
      chk("rst_we", 32'(we), 0);
      chk("rst_waddr", 32'(waddr), 0);
      chk("rst_wdata", 32'(wdata), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_aborted", 32'(aborted), 0);
      chk("rst_checksum", 32'(checksum), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_s_ready", 32'(s_ready), 0);
      phase = 0; taken = 0; sum = 0; m_chk = 0;
      e_we = 0; e_done = 0; e_ab = 0; e_waddr = 0; e_wdata = '0;
      repeat (ncyc) begin
         @(posedge clk); #1;
         chk("rst_hold_done", 32'(done), 0);
         chk("rst_hold_aborted", 32'(aborted), 0);
         chk("rst_hold_we", 32'(we), 0);
      end
      start = 1'b0; s_valid = 1'b0;
      rst_n = 1'b1;
   endtask

   // vmode: 0 valid always, 1 alternating, 2 random
   task automatic do_load(input int vmode, input int abort_at, input int reset_at, input bit poke);
      bit acc, v, ab, st;
      int d;
      int sent = 0;
      int guard = 0;
      cycle(1'b1, 1'b0, 1'b0, 0, acc);
      while (phase != 0) begin
         guard++;
         if (guard > 20 * NTAPS) begin
            chk("load_timeout", 1, 0);
            break;
         end
         if (reset_at >= 0 && sent == reset_at) begin
            do_reset(3);
            return;
         end
         case (vmode)
            0:       v = 1'b1;
            1:       v = (guard % 2) == 1;
            default: v = $urandom_range(0, 2) != 0;
         endcase
         d  = v ? coefs[sent % NTAPS] : int'($urandom);
         ab = (abort_at >= 0 && sent == abort_at && phase == 1) ||
              (phase == 2 && $urandom_range(0, 1) == 1);
         st = poke && ($urandom_range(0, 3) == 0);
         cycle(st, ab, v, d, acc);
         if (acc) sent++;
      end
   endtask

   initial begin
      bit acc;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
      repeat (3) @(posedge clk);
      #1;
      do_reset(1);

      // 1: 1..32 streaming
      for (int i = 0; i < NTAPS; i++) coefs[i] = i + 1;
      do_load(0, -1, -1, 1'b0);
      chk("sum_1to32", 32'(checksum), 528);

      // 4: abort after 10 accepts with valid high
      do_load(0, 10, -1, 1'b0);
      chk("abort_keeps_sum", 32'(checksum), 528);
      repeat (3) cycle(1'b0, 1'b0, 1'b1, 5, acc);

      // 2: alternating valid
      do_load(1, -1, -1, 1'b0);
      chk("sum_toggle", 32'(checksum), 528);

      // 3: all most-negative
      for (int i = 0; i < NTAPS; i++) coefs[i] = -32768;
      do_load(0, -1, -1, 1'b0);
      chk("sum_neg", 32'(checksum), 32'h100000);

      // 5: abort in idle ignored, start during load ignored
      cycle(1'b0, 1'b1, 1'b1, 3, acc);
      cycle(1'b0, 1'b1, 1'b0, 0, acc);
      for (int i = 0; i < NTAPS; i++) coefs[i] = i + 1;
      do_load(2, -1, -1, 1'b1);
      chk("sum_poked", 32'(checksum), 528);

      // 6: reset mid-load then a load of 7s
      do_load(0, -1, 5, 1'b0);
      for (int i = 0; i < NTAPS; i++) coefs[i] = 7;
      do_load(0, -1, -1, 1'b0);
      chk("sum_sevens", 32'(checksum), 224);

      // random loads, some aborted, some back-to-back
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < NTAPS; i++) coefs[i] = int'($signed(CW'($urandom)));
         do_load(2, (r % 3 == 2) ? int'($urandom_range(0, NTAPS - 1)) : -1, -1, 1'b1);
         if (r % 2 == 1) repeat ($urandom_range(0, 3)) cycle(1'b0, 1'b1, 1'b1, 1, acc);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
